// File: rtl/mips_trc_pkg.sv
// Shared types and defaults for the memory-write tracer: checker state encoding
// and the default self-check signature (address/value) used by the CPU test programs.
package mips_trc_pkg;

    typedef enum logic [1:0] {
        CHK_RUN  = 2'd0,
        CHK_PASS = 2'd1,
        CHK_FAIL = 2'd2
    } chk_state_t;

    localparam logic [31:0] TRC_DONE_ADDR = 32'h0000_0054;
    localparam logic [31:0] TRC_DONE_DATA = 32'h0000_0007;

endpackage

// File: rtl/mem_write_tracer_fifo.sv
// Synchronous first-word-fall-through FIFO; head read combinationally from storage.
// Latency: pushed entry visible the cycle after the push edge (no bypass).
// Backpressure: push into a full FIFO is dropped (flagged on drop) unless a pop happens in the same cycle.
module trc_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         res,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         drop
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         pop_ok;
    logic         push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;

    // Head reads as zero when empty so the outputs are clean out of reset.
    assign dout = empty ? '0 : mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_write_tracer.sv
// Traces every CPU store as (addr, data) into a FWFT buffer and watches for the signature store.
// Latency: store in cycle N is at the head / counted / checked in cycle N+1.
// Backpressure: none towards the CPU; stores arriving at a full buffer are dropped and overflow_o sticks.
// Build option MEMTRC_ADDR_FILTER_EN restricts buffered stores to FILT_LO..FILT_HI.
module mem_write_tracer
    import mips_trc_pkg::*;
#(
    parameter int            DEPTH     = 8,
    parameter int            AW        = 32,
    parameter int            DW        = 32,
    parameter logic [AW-1:0] DONE_ADDR = AW'(TRC_DONE_ADDR),
    parameter logic [DW-1:0] DONE_DATA = DW'(TRC_DONE_DATA),
    parameter logic [AW-1:0] FILT_LO   = '0,
    parameter logic [AW-1:0] FILT_HI   = '1
) (
    input  logic          clk,
    input  logic          res,
    input  logic          memwrite_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          trc_valid_o,
    input  logic          trc_ready_i,
    output logic [AW-1:0] trc_addr_o,
    output logic [DW-1:0] trc_data_o,
    output logic [15:0]   wr_count_o,
    output logic          overflow_o,
    output logic          done_o,
    output logic          pass_o
);

    logic                 push;
    logic [AW+DW-1:0]     head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_drop;
    chk_state_t           state;
    chk_state_t           state_nxt;

`ifdef MEMTRC_ADDR_FILTER_EN
    assign push = memwrite_i && (addr_i >= FILT_LO) && (addr_i <= FILT_HI);
`else
    logic unused_filt;
    assign unused_filt = ^{FILT_LO, FILT_HI};
    assign push = memwrite_i;
`endif

    trc_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (push),
        .din   ({addr_i, wdata_i}),
        .pop   (trc_ready_i),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    logic unused_full;
    assign unused_full = fifo_full;

    assign trc_valid_o = !fifo_empty;
    assign trc_addr_o  = head[AW+DW-1:DW];
    assign trc_data_o  = head[DW-1:0];

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wr_count_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (memwrite_i && (wr_count_o != 16'hFFFF)) wr_count_o <= wr_count_o + 16'd1;
            if (fifo_drop) overflow_o <= 1'b1;
        end
    end

    // Signature checker: first store to DONE_ADDR decides the verdict for good.
    always_ff @(posedge clk or negedge res) begin
        if (!res) state <= CHK_RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_o    = 1'b0;
        pass_o    = 1'b0;
        case (state)
            CHK_RUN: begin
                if (memwrite_i && (addr_i == DONE_ADDR))
                    state_nxt = (wdata_i == DONE_DATA) ? CHK_PASS : CHK_FAIL;
            end
            CHK_PASS: begin
                done_o = 1'b1;
                pass_o = 1'b1;
            end
            CHK_FAIL: begin
                done_o = 1'b1;
            end
            default: state_nxt = CHK_RUN;
        endcase
    end

endmodule

// File: tb/tb_mem_write_tracer.sv
// Self-checking bench for mem_write_tracer: directed scenarios plus randomized traffic
// against a queue-based transaction model.
module tb_mem_write_tracer;

    localparam int DEPTH = 8;
`ifdef MEMTRC_ADDR_FILTER_EN
    localparam logic [31:0] F_LO = 32'h40;
    localparam logic [31:0] F_HI = 32'h5C;
`else
    localparam logic [31:0] F_LO = 32'h0;
    localparam logic [31:0] F_HI = 32'hFFFF_FFFF;
`endif

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready = 1'b0;
    logic        trc_valid;
    logic [31:0] trc_addr;
    logic [31:0] trc_data;
    logic [15:0] wr_count;
    logic        overflow;
    logic        done;
    logic        pass;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        m_q[$];
    int unsigned m_cnt;
    logic        m_ovf;
    logic        m_done;
    logic        m_pass;

    always #5 clk = ~clk;

    mem_write_tracer #(
        .DEPTH   (DEPTH),
        .FILT_LO (F_LO),
        .FILT_HI (F_HI)
    ) dut (
        .clk         (clk),
        .res         (res),
        .memwrite_i  (memwrite),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .trc_valid_o (trc_valid),
        .trc_ready_i (ready),
        .trc_addr_o  (trc_addr),
        .trc_data_o  (trc_data),
        .wr_count_o  (wr_count),
        .overflow_o  (overflow),
        .done_o      (done),
        .pass_o      (pass)
    );

    function automatic logic in_window(input logic [31:0] a);
`ifdef MEMTRC_ADDR_FILTER_EN
        return (a >= 32'h40) && (a <= 32'h5C);
`else
        return (a == a);
`endif
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
        m_pass = 1'b0;
    endtask

    // One clock of stimulus; called at a negedge, returns at the next negedge.
    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        bit popped;
        memwrite = mw;
        addr     = a;
        wdata    = d;
        ready    = rdy;
        @(posedge clk);
        popped = rdy && (m_q.size() > 0);
        if (popped) void'(m_q.pop_front());
        if (mw) begin
            if (m_cnt < 65535) m_cnt++;
            if (in_window(a)) begin
                if (m_q.size() < DEPTH) m_q.push_back('{a: a, d: d});
                else m_ovf = 1'b1;
            end
            if (!m_done && a == 32'h54) begin
                m_done = 1'b1;
                m_pass = (d == 32'h7);
            end
        end
        @(negedge clk);
        memwrite = 1'b0;
        ready    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        res = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({trc_valid, trc_addr, trc_data, wr_count, overflow, done, pass} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b addr=%h data=%h cnt=%0d ovf=%b done=%b pass=%b, want all zero",
                     trc_valid, trc_addr, trc_data, wr_count, overflow, done, pass);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        step(1'b1, 32'h10, 32'hA, 1'b0);
        checks++;
        if (trc_valid !== 1'b1 || trc_addr !== 32'h10 || trc_data !== 32'hA) begin
            errors++;
            $display("FAIL basic_first: got v=%b %h/%h, want 1 00000010/0000000a", trc_valid, trc_addr, trc_data);
        end
        step(1'b1, 32'h14, 32'hB, 1'b0);
        checks++;
        if (wr_count !== 16'd2 || trc_addr !== 32'h10 || trc_data !== 32'hA) begin
            errors++;
            $display("FAIL basic_second: got cnt=%0d head=%h/%h, want 2 00000010/0000000a", wr_count, trc_addr, trc_data);
        end
        step(1'b0, 0, 0, 1'b1);
        checks++;
        if (trc_valid !== 1'b1 || trc_addr !== 32'h14 || trc_data !== 32'hB) begin
            errors++;
            $display("FAIL basic_pop: got v=%b %h/%h, want 1 00000014/0000000b", trc_valid, trc_addr, trc_data);
        end
        step(1'b0, 0, 0, 1'b1);
        checks++;
        if (trc_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_empty: got valid=%b want 0", trc_valid);
        end
        // Push and ready together on an empty buffer: no bypass.
        step(1'b1, 32'h20, 32'hC, 1'b1);
        checks++;
        if (trc_valid !== 1'b1 || trc_addr !== 32'h20) begin
            errors++;
            $display("FAIL no_bypass: got v=%b addr=%h, want 1 00000020", trc_valid, trc_addr);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 32'h100 + 4 * i, 32'h1000 + i, 1'b0);
        checks++;
        if (overflow !== 1'b1 || wr_count !== 16'd9) begin
            errors++;
            $display("FAIL overflow_flag: got ovf=%b cnt=%0d, want 1 9", overflow, wr_count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (trc_valid !== 1'b1 || trc_addr !== 32'h100 + 4 * i || trc_data !== 32'h1000 + i) begin
                errors++;
                $display("FAIL overflow_drain[%0d]: got v=%b %h/%h, want 1 %h/%h", i, trc_valid,
                         trc_addr, trc_data, 32'h100 + 4 * i, 32'h1000 + i);
            end
            step(1'b0, 0, 0, 1'b1);
        end
        checks++;
        if (trc_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_after: got v=%b ovf=%b, want 0 1", trc_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 32'h200 + 4 * i, 32'h2000 + i, 1'b0);
        step(1'b1, 32'h2FC, 32'hBEEF, 1'b1);
        checks++;
        if (overflow !== 1'b0 || trc_addr !== 32'h204) begin
            errors++;
            $display("FAIL full_push_pop: got ovf=%b head=%h, want 0 00000204", overflow, trc_addr);
        end
        for (int i = 1; i < 9; i++) begin
            checks++;
            if (trc_addr !== ((i == 8) ? 32'h2FC : 32'h200 + 4 * i) ||
                trc_data !== ((i == 8) ? 32'hBEEF : 32'h2000 + i)) begin
                errors++;
                $display("FAIL full_drain[%0d]: got %h/%h", i, trc_addr, trc_data);
            end
            step(1'b0, 0, 0, 1'b1);
        end
    endtask

    task automatic test_checker();
        do_reset();
        step(1'b1, 32'h54, 32'h7, 1'b1);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL chk_pass: got done=%b pass=%b, want 1 1", done, pass);
        end
        step(1'b1, 32'h54, 32'h3, 1'b1);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL chk_sticky: got done=%b pass=%b, want 1 1", done, pass);
        end
        do_reset();
        step(1'b1, 32'h50, 32'h7, 1'b1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL chk_other_addr: got done=%b want 0", done);
        end
        step(1'b1, 32'h54, 32'h3, 1'b1);
        step(1'b1, 32'h54, 32'h7, 1'b1);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL chk_fail: got done=%b pass=%b, want 1 0", done, pass);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1'b1, (i == 2) ? 32'h54 : 32'h40 + 4 * i, 32'h7, 1'b0);
        checks++;
        if (trc_valid !== 1'b1 || done !== 1'b1 || wr_count !== 16'd5) begin
            errors++;
            $display("FAIL midrst_pre: got v=%b done=%b cnt=%0d, want 1 1 5", trc_valid, done, wr_count);
        end
        res = 1'b0;
        model_clear();
        #1;
        checks++;
        if (trc_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got valid=%b want 0", trc_valid);
        end
        memwrite = 1'b1;
        addr     = 32'h54;
        wdata    = 32'h7;
        @(negedge clk);
        memwrite = 1'b0;
        res      = 1'b1;
        @(negedge clk);
        checks++;
        if ({trc_valid, wr_count, overflow, done, pass} !== '0) begin
            errors++;
            $display("FAIL midrst_post: got v=%b cnt=%0d ovf=%b done=%b pass=%b, want all 0",
                     trc_valid, wr_count, overflow, done, pass);
        end
    endtask

`ifdef MEMTRC_ADDR_FILTER_EN
    task automatic test_filter();
        do_reset();
        step(1'b1, 32'h3C, 32'h1, 1'b0);
        step(1'b1, 32'h40, 32'h2, 1'b0);
        step(1'b1, 32'h60, 32'h3, 1'b0);
        checks++;
        if (wr_count !== 16'd3 || trc_addr !== 32'h40 || trc_data !== 32'h2) begin
            errors++;
            $display("FAIL filter_head: got cnt=%0d head=%h/%h, want 3 00000040/00000002", wr_count, trc_addr, trc_data);
        end
        step(1'b0, 0, 0, 1'b1);
        checks++;
        if (trc_valid !== 1'b0) begin
            errors++;
            $display("FAIL filter_only_one: got valid=%b want 0", trc_valid);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] ea;
        logic [31:0] ed;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            ea = (m_q.size() > 0) ? m_q[0].a : 32'h0;
            ed = (m_q.size() > 0) ? m_q[0].d : 32'h0;
            checks++;
            if (trc_valid !== (m_q.size() > 0) || trc_addr !== ea || trc_data !== ed ||
                wr_count !== m_cnt[15:0] || overflow !== m_ovf || done !== m_done || pass !== m_pass) begin
                errors++;
                $display("FAIL random[%0d]: got v=%b %h/%h cnt=%0d ovf=%b d=%b p=%b, want v=%b %h/%h cnt=%0d ovf=%b d=%b p=%b",
                         c, trc_valid, trc_addr, trc_data, wr_count, overflow, done, pass,
                         m_q.size() > 0, ea, ed, m_cnt, m_ovf, m_done, m_pass);
            end
            if (c == 300) do_reset();
            step($urandom_range(0, 99) < 60, 32'h30 + 4 * $urandom_range(0, 14),
                 $urandom_range(0, 9), $urandom_range(0, 99) < 40);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
`ifdef MEMTRC_ADDR_FILTER_EN
        test_filter();
`else
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
`endif
        test_checker();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_write_tracer.md
# mem_write_tracer

Monitors the data-memory write port leaving the CPU's MEM stage and records every store as an (address, data) pair in a small first-word-fall-through buffer, drained through a valid/ready stream. It also detects the self-check signature store (a write to `DONE_ADDR`) and flags pass or fail. Sits directly downstream of the CPU core, beside data memory, and is instantiated by the CPU testbench and FPGA debug top.

## Interface
- `DEPTH`, 8: trace buffer entries; power of two, at least 2.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `DONE_ADDR`, 32'h54: signature address.
- `DONE_DATA`, 32'h7: expected signature value.
- `FILT_LO`, 32'h0: lowest captured address (filter build only).
- `FILT_HI`, 32'hFFFF_FFFF: highest captured address (filter build only).

- `clk`  in  1  single clock, all state on rising edge.
- `res`  in  1  reset; asynchronous assert, active-low (0 = reset).
- `memwrite_i`  in  1  store strobe from the MEM stage, one per store.
- `addr_i`  in  AW  store address (ALU result).
- `wdata_i`  in  DW  store data.
- `trc_valid_o`  out  1  head entry available.
- `trc_ready_i`  in  1  consumer accepts head entry.
- `trc_addr_o`  out  AW  head entry address.
- `trc_data_o`  out  DW  head entry data.
- `wr_count_o`  out  16  saturating count of store strobes seen.
- `overflow_o`  out  1  sticky: at least one store dropped because the buffer was full.
- `done_o`  out  1  signature store seen.
- `pass_o`  out  1  signature store carried `DONE_DATA`; valid only when `done_o` is 1.

## Operation
- Push: `memwrite_i`=1 (and, in the filter build, address in window) enqueues {`addr_i`, `wdata_i`}.
- Pop: `trc_valid_o` && `trc_ready_i` dequeues the head entry. The head is presented combinationally from storage.
- Full, with push and no pop: entry dropped, `overflow_o` set. `overflow_o` stays set until reset.
- Full, with push and pop in the same cycle: push accepted, occupancy unchanged, no overflow.
- Empty, with push and ready in the same cycle: no bypass. The entry appears on the next cycle.
- Pointers are log2(`DEPTH`)+1 bits and wrap modulo 2·`DEPTH`.
  - Full: MSBs differ and the low bits are equal.
  - Empty: pointers are equal.
- `wr_count_o` increments on every `memwrite_i`, including dropped and filtered stores, and saturates at 16'hFFFF.
- Checker FSM, states RUN, PASS, FAIL:
  - RUN→PASS on a store to `DONE_ADDR` with `DONE_DATA`.
  - RUN→FAIL on a store to `DONE_ADDR` with any other value.
  - PASS and FAIL are terminal until reset. Later signature stores are ignored by the FSM but still traced.
  - `done_o` = (state≠RUN); `pass_o` = (state==PASS).
- Reset values: `trc_valid_o`=0, `trc_addr_o`=0, `trc_data_o`=0, `wr_count_o`=0, `overflow_o`=0, `done_o`=0, `pass_o`=0. Storage contents are not reset.

## Timing
- Store in cycle N gives `trc_valid_o`=1 in cycle N+1 (empty buffer).
- `wr_count_o`, `done_o` and `pass_o` update at the edge ending cycle N, visible in cycle N+1.
- All outputs are registered except `trc_addr_o` and `trc_data_o`, which are read from the head of the storage array.
- `res` asserted mid-stream empties the buffer asynchronously. `trc_valid_o` drops immediately and in-flight entries are lost.
- No `memwrite_i` is captured while `res`=0.
- The first capture is possible on the first rising edge after `res` deasserts.

## Configuration
- `MEMTRC_ADDR_FILTER_EN` defined: only stores with `FILT_LO` ≤ `addr_i` ≤ `FILT_HI` (unsigned) are pushed.
- `MEMTRC_ADDR_FILTER_EN` undefined: every store is pushed, and `FILT_LO`/`FILT_HI` are ignored.
- In both builds, `wr_count_o` and the checker FSM see all stores.

## Structure
- Package `mips_trc_pkg` holds:
  - the checker state encoding (RUN=2'd0, PASS=2'd1, FAIL=2'd2);
  - default constants `TRC_DONE_ADDR` and `TRC_DONE_DATA`.
- One sub-module, `trc_fifo`: parameterised synchronous FWFT FIFO with push/pop/full/empty.
- The top level holds the filter, counter, overflow flag and FSM.

## Test plan
- Reset release, then stores (0x10,0xA) and (0x14,0xB) in consecutive cycles with `trc_ready_i`=0 → `trc_valid_o`=1 from the next cycle, head (0x10,0xA); `wr_count_o`=2.
- 9 stores with `DEPTH`=8 and no pops → 8 entries held, `overflow_o`=1, `wr_count_o`=9; draining with ready=1 yields the first 8 in order.
- Buffer full, then store plus pop in the same cycle → no overflow; drain order shows the new entry last.
- Store (0x54,0x7) → `done_o`=1 and `pass_o`=1 next cycle; a later (0x54,0x3) leaves `pass_o`=1. A separate run with (0x54,0x3) first → `done_o`=1, `pass_o`=0.
- `res`=0 pulse while 5 entries are queued → `trc_valid_o`=0 immediately; all counters and flags are 0 after release.
- Filter build with `FILT_LO`=0x40, `FILT_HI`=0x5C; stores to 0x3C, 0x40, 0x60 → only 0x40 queued; `wr_count_o`=3.
